mult_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one combinational 16x16 Dadda multiplier (33-bit product) among `NREQ` requesters. It accepts one operand pair per transaction over a valid/ready handshake and drives the multiplier from registered operands. It waits a configurable number of settle cycles for the combinational tree to resolve, then captures the product and returns it to the granted requester. It sits between the client blocks and the multiplier instance; the multiplier itself stays purely combinational.

---
 rtl/mult_share_ctrl.sv | 159 +++++++++++++++
 tb/tb_mult_share_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
// Shares one combinational 16x16 multiplier (33-bit product) among NREQ
// requesters. A round-robin arbiter accepts one operand pair, the operands
// are held in registers for SETTLE cycles while the multiplier tree
// resolves, then the product is captured and returned to the owner.
//
// Optional feature: define MULT_SHARE_ZERO_BYPASS_EN so that a zero operand
// skips the settle wait and returns a zero product one cycle after accept.
module mult_share_ctrl #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [32:0]          mul_c,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [32:0]          rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [NREQ-1:0]  ONE_HOT0   = NREQ'(1);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE - 1);

    logic [1:0]       state_q,      state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] owner_q,      owner_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [15:0]      mul_a_q,      mul_a_d;
    logic [15:0]      mul_b_q,      mul_b_d;
    logic [32:0]      rsp_data_q,   rsp_data_d;

    logic             any_valid;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx_v;
    logic [15:0]      win_a;
    logic [15:0]      win_b;

    // Round-robin search: first valid requester at or after last_grant+1, with wrap.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        any_valid = 1'b0;
        winner    = last_grant_q;
        idx_v     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v = IDX_W'((int'(last_grant_q) + k) % NREQ);
            if (!any_valid && req_valid[idx_v]) begin
                any_valid = 1'b1;
                winner    = idx_v;
            end
        end
    end

    // Operand mux selecting the winner's packed multiplicand and multiplier.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_a = req_a[i*16 +: 16];
                win_b = req_b[i*16 +: 16];
            end
        end
    end

    // Sequencer: accept in IDLE, hold operands through WAIT, present result in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    mul_a_d      = win_a;
                    mul_b_d      = win_b;
                    owner_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_WAIT;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
                    // A zero operand has a known product; skip the settle wait.
                    if ((win_a == 16'h0) || (win_b == 16'h0)) begin
                        rsp_data_d = '0;
                        cnt_d      = '0;
                        state_d    = S_RESP;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = mul_c;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                // Only the owner's acceptance completes the transaction.
                if (rsp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_RESET;
            owner_q      <= '0;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == S_IDLE && any_valid) ? (ONE_HOT0 << winner) : '0;
    assign rsp_valid = (state_q == S_RESP) ? (ONE_HOT0 << owner_q) : '0;
    assign busy      = (state_q != S_IDLE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl. Models the shared multiplier as
// a combinational product and predicts grants, latencies and products from
// a transaction-level reference (round-robin pick + plain arithmetic).
// Honours MULT_SHARE_ZERO_BYPASS_EN when predicting latency.
module tb_mult_share_ctrl;

    localparam int NREQ   = 4;
    localparam int SETTLE = 3;
    localparam logic [NREQ-1:0] ONE = 4'b0001;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic [32:0]          mul_c;
    logic [NREQ-1:0]      rsp_valid;
    logic [32:0]          rsp_data;
    logic [NREQ-1:0]      rsp_ready;
    logic                 busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int last_g   = NREQ - 1;

    mult_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // Behavioural stand-in for the combinational Dadda multiplier.
    assign mul_c = 33'(mul_a) * 33'(mul_b);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first set bit at or after last+1, wrapping.
    function automatic int pick(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        last_g = NREQ - 1;
    endtask

    // One full transaction starting at a negedge with the DUT idle.
    task automatic txn(input string tag, input logic [NREQ-1:0] vmask,
                       input logic [16*NREQ-1:0] av, input logic [16*NREQ-1:0] bv,
                       input int hold);
        int          win;
        int          lat;
        int          exp_lat;
        logic [15:0] a;
        logic [15:0] b;
        logic [32:0] prod;
        win     = pick(vmask, last_g);
        a       = av[16*win +: 16];
        b       = bv[16*win +: 16];
        prod    = 33'(a) * 33'(b);
        exp_lat = SETTLE + 1;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
        if (a == 16'h0 || b == 16'h0) exp_lat = 1;
`endif
        req_valid = vmask;
        req_a     = av;
        req_b     = bv;
        rsp_ready = '0;
        #1;
        check({tag, "/req_ready"}, req_ready, ONE << win);
        check({tag, "/idle_busy"}, busy, 0);
        @(negedge clk);
        req_valid = '0;
        check({tag, "/mul_a"}, mul_a, a);
        check({tag, "/mul_b"}, mul_b, b);
        lat = 1;
        while (rsp_valid == '0 && lat < 20) begin
            rsp_ready = '1;          // early acceptance must be ignored
            @(negedge clk);
            rsp_ready = '0;
            lat++;
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/rsp_valid"}, rsp_valid, ONE << win);
        check({tag, "/rsp_data"}, rsp_data, prod);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 4'($urandom) & ~(ONE << win);
            req_valid = 4'($urandom);
            @(negedge clk);
            check({tag, "/hold_valid"}, rsp_valid, ONE << win);
            check({tag, "/hold_data"}, rsp_data, prod);
            check({tag, "/hold_no_ready"}, req_ready, 0);
        end
        rsp_ready = (ONE << win) | 4'($urandom);
        req_valid = '0;
        @(negedge clk);
        rsp_ready = '0;
        check({tag, "/done_busy"}, busy, 0);
        check({tag, "/done_valid"}, rsp_valid, 0);
        last_g = win;
    endtask

    initial begin
        logic [16*NREQ-1:0] av;
        logic [16*NREQ-1:0] bv;
        logic [NREQ-1:0]    m;
        int n_acc;
        int prev_c;
        int owner;
        int bad_rsp;

        req_a = '0;
        req_b = '0;
        do_reset();

        // Reset values.
        check("rst/rsp_valid", rsp_valid, 0);
        check("rst/req_ready", req_ready, 0);
        check("rst/busy", busy, 0);
        check("rst/mul_a", mul_a, 0);
        check("rst/mul_b", mul_b, 0);
        check("rst/rsp_data", rsp_data, 0);

        // Requester 0: 3*5.
        txn("t_basic", 4'b0001, {48'h0, 16'h0003}, {48'h0, 16'h0005}, 0);

        // Requester 2 with maximal operands, response held off 5 cycles.
        txn("t_hold", 4'b0100, {16'h0, 16'hFFFF, 32'h0}, {16'h0, 16'hFFFF, 32'h0}, 5);

        // Zero operand (latency depends on the bypass option).
        txn("t_zero", 4'b0010, {32'h0, 16'h0000, 16'h0}, {32'h0, 16'h1234, 16'h0}, 0);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                av[16*i +: 16] = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
                bv[16*i +: 16] = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            end
            txn("t_rand", m, av, bv, $urandom_range(0, 3));
        end

        // Saturation: all requesters valid, responses accepted immediately.
        do_reset();
        req_a     = {16'd4, 16'd3, 16'd2, 16'd1};
        req_b     = {16'd13, 16'd12, 16'd11, 16'd10};
        req_valid = '1;
        rsp_ready = '1;
        n_acc  = 0;
        prev_c = 0;
        owner  = -1;
        for (int c = 0; c < 60 && n_acc < 5; c++) begin
            #1;
            if (rsp_valid != '0 && owner >= 0) begin
                check("sat/rsp_valid", rsp_valid, ONE << owner);
                check("sat/rsp_data", rsp_data, 33'((owner + 1) * (owner + 10)));
            end
            if (req_ready != '0) begin
                check("sat/grant", req_ready, ONE << (n_acc % NREQ));
                if (n_acc > 0) check("sat/spacing", c - prev_c, SETTLE + 2);
                prev_c = c;
                owner  = n_acc % NREQ;
                n_acc++;
            end
            @(negedge clk);
        end
        check("sat/accepts", n_acc, 5);

        // Reset during WAIT of a grant to requester 1.
        do_reset();
        req_a     = {32'h0, 16'h0007, 16'h0};
        req_b     = {32'h0, 16'h0009, 16'h0};
        req_valid = 4'b0010;
        #1;
        check("abort/req_ready", req_ready, 4'b0010);
        @(negedge clk);
        check("abort/in_wait", busy, 1);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort/rsp_valid", rsp_valid, 0);
        check("abort/req_ready0", req_ready, 0);
        check("abort/busy", busy, 0);
        check("abort/mul_a", mul_a, 0);
        check("abort/mul_b", mul_b, 0);
        check("abort/rsp_data", rsp_data, 0);
        bad_rsp   = 0;
        rsp_ready = '1;
        for (int c = 0; c < SETTLE + 4; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) bad_rsp++;
        end
        rsp_ready = '0;
        check("abort/no_rsp", bad_rsp, 0);
        req_valid = '1;
        #1;
        check("abort/first_grant", req_ready, 4'b0001);
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
